// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl: unified word memory with programmable latency and ready pulse; MEM_MISALIGN_TRAP_EN enables misaligned-access trap
module mem_wait_ctrl #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [AW-1:0] idx_q, cur_idx;
  logic [31:0] wdata_q;
  logic wr_q, mis_q, accept, mis_now, cur_wr, cur_mis, unused_addr;
  logic [31:0] mem [DEPTH];
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_now = |addr[1:0];
`else
  assign mis_now = 1'b0;
`endif
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign accept  = (state == IDLE) && (req_read || req_write);
  assign cur_wr  = (state == IDLE) ? req_write : wr_q;
  assign cur_mis = (state == IDLE) ? mis_now : mis_q;
  assign cur_idx = (state == IDLE) ? addr[AW+1:2] : idx_q;
  assign busy    = (state != IDLE);
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_n;
  // next state: a single-cycle latency skips BUSY so ready lands LATENCY cycles after the accepting cycle
  always_comb begin
    state_n = IDLE;
    state_n = (state == IDLE) ? (accept ? ((LATENCY == 1) ? RESP : BUSY) : IDLE)
            : (state == BUSY) ? ((cnt == 4'd1) ? RESP : BUSY) : IDLE;
  end
  // request latch, latency counter and registered outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      mis_q   <= 1'b0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= 4'(LATENCY - 1);
        idx_q   <= addr[AW+1:2];
        wdata_q <= wdata;
        wr_q    <= req_write;
        mis_q   <= mis_now;
      end else if (state == BUSY) cnt <= cnt - 4'd1;
      ready <= (state_n == RESP);
      err   <= (state_n == RESP) && cur_mis;
      if ((state_n == RESP) && !cur_wr && !cur_mis) rdata <= mem[cur_idx];
    end
  // write commits on the edge leaving RESP, so a following access already sees it
  always_ff @(posedge clk)
    if ((state == RESP) && wr_q && !mis_q) mem[idx_q] <= wdata_q;
endmodule

// File: tb/tb_mem_wait_ctrl.sv
// tb_mem_wait_ctrl: randomized check of mem_wait_ctrl against an array-based reference model
module tb_mem_wait_ctrl;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic req_read = 1'b0, req_write = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic ready, busy, err;
  logic l_read = 1'b0, l_write = 1'b0;
  logic [31:0] l_addr = '0, l_wdata = '0, l_rdata;
  logic l_ready, l_busy, l_err;
  logic [31:0] mem_m [256];
  logic [31:0] dat [8];
  logic [31:0] exp_rdata = '0;
  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  mem_wait_ctrl u_dut (
    .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .err(err)
  );

  mem_wait_ctrl #(.DEPTH(256), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_read(l_read), .req_write(l_write),
    .addr(l_addr), .wdata(l_wdata), .rdata(l_rdata), .ready(l_ready), .busy(l_busy), .err(l_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d, input bit scramble);
    int n;
    bit busy_ok, mis;
    @(negedge clk);
    check("idle_busy", busy, 0);
    req_write = w; req_read = r; addr = a; wdata = d;
    @(posedge clk);
    n = 0; busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!busy) busy_ok = 1'b0;
      if (scramble && n == 1) begin addr = $urandom; wdata = $urandom; end
    end while (!ready && n < 20);
    req_write = 1'b0; req_read = 1'b0;
    check("latency", n, 2);
    check("busy_during", busy_ok, 1);
    mis = TRAP && (a[1:0] != 2'b00);
    if (!mis && w) mem_m[a[9:2]] = d;
    else if (!mis && r) exp_rdata = mem_m[a[9:2]];
    check("err", err, mis);
    check("rdata", rdata, exp_rdata);
    @(negedge clk);
    check("ready_pulse", ready, 0);
    check("busy_after", busy, 0);
  endtask

  task automatic held_run(input bit w);
    int k, cyc, last;
    @(negedge clk);
    k = 0; cyc = 0; last = 0;
    l_write = w; l_read = !w; l_addr = 32'h0; l_wdata = dat[0];
    while (k < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (l_ready) begin
        check(k == 0 ? "lat1_first" : "lat1_period", cyc - last, k == 0 ? 1 : 2);
        check("lat1_err", l_err, 0);
        if (!w) check("lat1_rdata", l_rdata, dat[k]);
        last = cyc;
        k++;
        l_addr = 32'(k * 4);
        l_wdata = dat[k % 8];
        if (k == 8) begin l_write = 1'b0; l_read = 1'b0; end
      end
    end
    check("lat1_done", k, 8);
    l_write = 1'b0; l_read = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) do_op(1'b1, 1'b0, 32'(i * 4), $urandom, 1'b0);
    do_op(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    do_op(1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
    check("raw_deadbeef", rdata, 32'hDEADBEEF);
    do_op(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0);
    check("both_keeps_rdata", rdata, 32'hDEADBEEF);
    do_op(1'b0, 1'b1, 32'h20, 32'h0, 1'b0);
    check("both_is_write", rdata, 32'h12345678);
    do_op(1'b1, 1'b0, 32'h400, 32'hA5A5A5A5, 1'b0);
    do_op(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    check("wrap", rdata, 32'hA5A5A5A5);
    @(negedge clk);
    req_write = 1'b1; addr = 32'h4; wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    check("mid_no_ready", ready, 0);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_rdata", rdata, 0);
    req_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_rdata = '0;
    do_op(1'b0, 1'b1, 32'h4, 32'h0, 1'b0);
    check("mid_not_55", rdata == 32'h55, 0);
    do_op(1'b1, 1'b0, 32'h13, 32'hFFFFFFFF, 1'b0);
    do_op(1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
    do_op(1'b0, 1'b1, 32'h24, 32'h0, 1'b1);
    do_op(1'b1, 1'b0, 32'h28, 32'hCAFEF00D, 1'b1);
    do_op(1'b0, 1'b1, 32'h28, 32'h0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      logic [1:0] kind;
      kind = 2'($urandom_range(0, 2));
      do_op(kind != 2'd1, kind != 2'd0, $urandom, $urandom, 1'($urandom));
    end
    for (int i = 0; i < 8; i++) dat[i] = $urandom;
    held_run(1'b1);
    held_run(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
